addsub_accumulator: RTL and testbench
=====================================

Name: addsub_accumulator

Overview:
- Sequential stage directly downstream of the 4-bit parallel adder/subtractor.
- Accepts a stream of {opcode, operand} commands over a valid/ready handshake and buffers them in a small FIFO.
- Applies each command to a running 4-bit accumulator using the same add/subtract semantics as the adder/subtractor: cin_mode=1 computes a + ~b + 1.
- Emits each result with carry, signed-overflow and zero flags over a registered valid/ready output.

Parameters:
- WIDTH, 4, datapath and accumulator width in bits.
- DEPTH, 4, command FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  command present
- in_ready  output  1  FIFO can accept a command
- in_op  input  2  opcode: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
- in_data  input  WIDTH  operand b (ignored for CLEAR)
- out_valid  output  1  result register holds an unaccepted result
- out_ready  input  1  consumer accepts the result
- out_sum  output  WIDTH  new accumulator value
- out_cout  output  1  raw carry out of the MSB
- out_ovf  output  1  two's-complement overflow
- out_zero  output  1  out_sum == 0
- acc  output  WIDTH  current accumulator value

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - acc = 0, FIFO empty (pointers and count = 0).
  - out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0.
  - in_ready = 1 once reset is deasserted.
- Asserting rst mid-operation discards all queued commands and any pending result immediately, without waiting for a clock edge.
- in_ready = !fifo_full. It is combinational from the FIFO count only and does not depend on in_valid.
- Push: a command is written when in_valid && in_ready at a rising edge.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
  - Push and pop in the same cycle on a non-full FIFO both take effect; the count is unchanged.
- Pop/execute condition: fire = !fifo_empty && (!out_valid || out_ready).
- When fire is true, the head command executes using the current acc as operand a. At the edge:
  - acc and out_sum are loaded with the result.
  - The flags are registered.
  - out_valid is set to 1.
- Opcode results (all arithmetic modulo 2^WIDTH):
  - ADD: {cout, sum} = acc + b + 0; ovf = (acc[MSB] == b[MSB]) && (sum[MSB] != acc[MSB]).
  - SUB: {cout, sum} = acc + ~b + 1. cout = 1 means no borrow (acc >= b unsigned). ovf = (acc[MSB] != b[MSB]) && (sum[MSB] != acc[MSB]).
  - LOAD: sum = b, cout = 0, ovf = 0.
  - CLEAR: sum = 0, cout = 0, ovf = 0.
  - out_zero = (sum == 0) for every opcode.
- Output handshake:
  - A transfer occurs when out_valid && out_ready.
  - If a transfer occurs and fire is false, out_valid clears to 0.
  - While out_valid && !out_ready, out_sum and all flags hold stable.
- Latency: a command accepted at edge N with the FIFO empty and no output stall appears at out_valid after edge N+1 (2-cycle input-to-output).
- Throughput: 1 command per cycle when out_ready is held high.
- Capacity under full backpressure: DEPTH commands in the FIFO plus 1 in the output register, i.e. 5 commands with the defaults.
- FIFO pointers wrap modulo DEPTH. The count is tracked separately so that full and empty are unambiguous.
- acc changes only on fire.

Test Plan:
- Reset, then LOAD 1100 and ADD 0101, with out_ready = 1 → results: 1100 (c0, v0, z0), then 0001 with cout=1, ovf=0, zero=0; acc=0001.
- LOAD 1100, SUB 0101 → sum=0111, cout=1, ovf=1 (−4 − 5 overflows).
- LOAD 0111, ADD 1111 → sum=0110, cout=1, ovf=0. Then LOAD 0111, SUB 1111 → sum=1000, cout=0, ovf=1.
- Hold out_ready = 0 and offer 6 commands back-to-back:
  - 5 are accepted; in_ready drops low after the 5th push; the 6th stalls.
  - out_sum holds the 1st result, stable.
  - Then raise out_ready: all results drain in order, one per cycle, and the 6th command is accepted.
- CLEAR, then SUB 0001 → results 0000 (zero=1), then 1111 with cout=0, ovf=0, zero=0.
- Queue 3 commands with out_ready = 0, then pulse rst between clock edges → out_valid, acc and in_ready reach their reset values immediately. After reset, ADD 0011 gives sum=0011; no stale results appear.

Source files
------------

// File: rtl/addsub_accumulator.sv
// Command-queued 4-bit add/subtract accumulator. Commands wait in a small FIFO and
// execute against the running accumulator; each result is held in a valid/ready output register.
module addsub_accumulator #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CMD_W = WIDTH + 2;
  localparam int unsigned MSB   = WIDTH - 1;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_zero_q, out_zero_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             fire;

  logic [CMD_W-1:0] head;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_b;
  logic [WIDTH:0]   ext_sum;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;

  assign fifo_full  = (cnt_q == CNT_W'(DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign fire       = !fifo_empty && (!out_valid_q || out_ready);

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_op, in_data};
  end

  assign head    = mem_q[rd_ptr_q];
  assign head_op = head[CMD_W-1 -: 2];
  assign head_b  = head[WIDTH-1:0];

  // Execute the head command against the current accumulator
  always_comb begin
    ext_sum  = '0;
    res_sum  = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    case (head_op)
      OP_ADD: begin
        ext_sum  = {1'b0, acc_q} + {1'b0, head_b};
        res_sum  = ext_sum[WIDTH-1:0];
        res_cout = ext_sum[WIDTH];
        res_ovf  = (acc_q[MSB] == head_b[MSB]) && (res_sum[MSB] != acc_q[MSB]);
      end
      OP_SUB: begin
        ext_sum  = {1'b0, acc_q} + {1'b0, ~head_b} + (WIDTH+1)'(1);
        res_sum  = ext_sum[WIDTH-1:0];
        res_cout = ext_sum[WIDTH];
        res_ovf  = (acc_q[MSB] != head_b[MSB]) && (res_sum[MSB] != acc_q[MSB]);
      end
      OP_LOAD:  res_sum = head_b;
      OP_CLEAR: res_sum = '0;
      default:  res_sum = '0;
    endcase
  end

  // Output register: load on fire, otherwise drop valid once the consumer takes it
  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_zero_d  = out_zero_q;
    if (fire) begin
      acc_d       = res_sum;
      out_valid_d = 1'b1;
      out_sum_d   = res_sum;
      out_cout_d  = res_cout;
      out_ovf_d   = res_ovf;
      out_zero_d  = (res_sum == '0);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator: a vector table for single commands plus
// hand-written backpressure and mid-operation reset sequences.
module tb_addsub_accumulator;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_cout;
  logic       out_ovf;
  logic       out_zero;
  logic [3:0] acc;

  int errors = 0;
  int checks = 0;

  addsub_accumulator dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .acc(acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(logic [1:0] op, logic [3:0] data, logic [3:0] sum,
                              logic cout, logic ovf, logic zero);
    vec_t v;
    v.op = op; v.data = data; v.sum = sum; v.cout = cout; v.ovf = ovf; v.zero = zero;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Push one command and wait for its result with out_ready held high
  task automatic run_vec(input int i);
    int lat;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = vecs[i].op; in_data = vecs[i].data;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", i), 32'(lat), 32'd1);
    chk($sformatf("v%0d sum", i), 32'(out_sum), 32'(vecs[i].sum));
    chk($sformatf("v%0d cout", i), 32'(out_cout), 32'(vecs[i].cout));
    chk($sformatf("v%0d ovf", i), 32'(out_ovf), 32'(vecs[i].ovf));
    chk($sformatf("v%0d zero", i), 32'(out_zero), 32'(vecs[i].zero));
    chk($sformatf("v%0d acc", i), 32'(acc), 32'(vecs[i].sum));
  endtask

  initial begin
    logic [3:0] exp_q [6];
    int idx;
    int iters;
    int got;

    vecs[0]  = mk(LOAD, 4'b1100, 4'b1100, 0, 0, 0);
    vecs[1]  = mk(ADD,  4'b0101, 4'b0001, 1, 0, 0);
    vecs[2]  = mk(LOAD, 4'b1100, 4'b1100, 0, 0, 0);
    vecs[3]  = mk(SUB,  4'b0101, 4'b0111, 1, 1, 0);
    vecs[4]  = mk(LOAD, 4'b0111, 4'b0111, 0, 0, 0);
    vecs[5]  = mk(ADD,  4'b1111, 4'b0110, 1, 0, 0);
    vecs[6]  = mk(LOAD, 4'b0111, 4'b0111, 0, 0, 0);
    vecs[7]  = mk(SUB,  4'b1111, 4'b1000, 0, 1, 0);
    vecs[8]  = mk(CLR,  4'b1010, 4'b0000, 0, 0, 1);
    vecs[9]  = mk(SUB,  4'b0001, 4'b1111, 0, 0, 0);
    vecs[10] = mk(ADD,  4'b0001, 4'b0000, 1, 0, 1);
    vecs[11] = mk(ADD,  4'b0111, 4'b0111, 0, 0, 0);
    vecs[12] = mk(ADD,  4'b0001, 4'b1000, 0, 1, 0);

    rst = 1'b1; in_valid = 1'b0; in_op = ADD; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst acc", 32'(acc), 32'd0);
    chk("rst out_sum", 32'(out_sum), 32'd0);
    chk("rst flags", 32'({out_cout, out_ovf, out_zero}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_vec(i);

    // Full backpressure: 5 commands fit, the 6th stalls
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) exp_q[k] = 4'(k + 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp in_ready before push %0d", k), 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_op = (k == 0) ? LOAD : ADD; in_data = 4'd1;
      @(negedge clk);
    end
    chk("bp in_ready after 5th push", 32'(in_ready), 32'd0);
    in_op = ADD; in_data = 4'd1;
    repeat (3) begin
      @(negedge clk);
      chk("bp stalled in_ready", 32'(in_ready), 32'd0);
      chk("bp out_valid held", 32'(out_valid), 32'd1);
      chk("bp out_sum held", 32'(out_sum), 32'd1);
      chk("bp acc held", 32'(acc), 32'd1);
    end
    out_ready = 1'b1;
    idx = 0; iters = 0;
    while (idx < 6 && iters < 20) begin
      if (out_valid) begin
        chk($sformatf("drain result %0d", idx), 32'(out_sum), 32'(exp_q[idx]));
        idx++;
      end
      iters++;
      if (in_valid && in_ready) begin
        @(negedge clk);
        in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    chk("drain count", 32'(idx), 32'd6);
    chk("drain one per cycle", 32'(iters), 32'd6);
    chk("drain in_valid consumed", 32'(in_valid), 32'd0);
    chk("drain empty after", 32'(out_valid), 32'd0);

    // Mid-operation reset between clock edges
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_op = (k == 0) ? LOAD : ADD; in_data = 4'b0101;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre-rst out_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst acc", 32'(acc), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    chk("async rst out_sum", 32'(out_sum), 32'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_op = ADD; in_data = 4'b0011;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post-rst out_valid", 32'(out_valid), 32'd1);
    chk("post-rst sum", 32'(out_sum), 32'b0011);
    chk("post-rst flags", 32'({out_cout, out_ovf, out_zero}), 32'd0);
    got = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) got++;
    end
    chk("no stale results", 32'(got), 32'd0);
    chk("post-rst acc", 32'(acc), 32'b0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
